// File: rtl/ppu_spr_pkg.sv
// Shared definitions for the sprite evaluation engine.
// PPU_SPR_OVF_BUG_EN selects the 2C02 overflow-scan quirk in ppu_spr_eval.
package ppu_spr_pkg;

    localparam int N_SPR  = 64;
    localparam int N_SLOT = 8;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_CLR  = 4'd1;
    localparam logic [3:0] S_RDY  = 4'd2;
    localparam logic [3:0] S_CMP  = 4'd3;
    localparam logic [3:0] S_RB1  = 4'd4;
    localparam logic [3:0] S_RB2  = 4'd5;
    localparam logic [3:0] S_RB3  = 4'd6;
    localparam logic [3:0] S_WR   = 4'd7;
    localparam logic [3:0] S_DONE = 4'd8;

    localparam logic [31:0] OAM2_EMPTY = 32'hFFFF_FFFF;

    localparam int SPR_H8  = 8;
    localparam int SPR_H16 = 16;

    localparam int F_Y    = 24;
    localparam int F_TILE = 16;
    localparam int F_ATTR = 8;
    localparam int F_X    = 0;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] tile;
        logic [7:0] attr;
        logic [7:0] x;
    } spr_t;

    function automatic logic [31:0] pack_spr(input spr_t s);
        logic [31:0] w;
        w = '0;
        w[F_Y+:8]    = s.y;
        w[F_TILE+:8] = s.tile;
        w[F_ATTR+:8] = s.attr;
        w[F_X+:8]    = s.x;
        return w;
    endfunction

endpackage

// File: rtl/ppu_spr_range.sv
// Combinational sprite in-range test: scanline - Y with borrow,
// hit when no borrow and the row offset is below the sprite height.
module ppu_spr_range
    import ppu_spr_pkg::*;
(
    input  logic [7:0] y,
    input  logic [8:0] scanline,
    input  logic       h16,
    output logic       hit
);

    logic [9:0] diff;
    logic [8:0] lim;

    assign diff = {1'b0, scanline} - {2'b00, y};
    assign lim  = h16 ? 9'(SPR_H16) : 9'(SPR_H8);
    assign hit  = !diff[9] && (diff[8:0] < lim);

endmodule

// File: rtl/ppu_spr_eval.sv
// Sprite evaluation: clears secondary OAM, then copies in-range sprites.
// Define PPU_SPR_OVF_BUG_EN to reproduce the 2C02 overflow-scan bug.
module ppu_spr_eval
    import ppu_spr_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_start,
    input  logic [8:0]  i_scanline,
    input  logic        i_spr_h16,
    output logic [7:0]  o_oam_addr,
    input  logic [7:0]  i_oam_q,
    output logic [2:0]  o_oam2_addr,
    output logic [31:0] o_oam2_data,
    output logic        o_oam2_we,
    output logic        o_busy,
    output logic        o_done,
    output logic [3:0]  o_spr_cnt,
    output logic        o_spr0_in,
    output logic        o_overflow
);

    logic [3:0] state;
    logic [5:0] n;
    logic [1:0] m;
    logic [2:0] clr_idx;
    logic [8:0] line;
    logic       h16;
    spr_t       spr;
    logic [3:0] cnt;
    logic       spr0;
    logic       ovf;
    logic       hit;
    logic       last;
    logic       full;

    ppu_spr_range u_range (
        .y        (i_oam_q),
        .scanline (line),
        .h16      (h16),
        .hit      (hit)
    );

    assign last = (n == 6'(N_SPR - 1));
    assign full = (cnt == 4'(N_SLOT));

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state   <= S_IDLE;
            n       <= '0;
            m       <= '0;
            clr_idx <= '0;
            line    <= '0;
            h16     <= 1'b0;
            spr     <= '0;
            cnt     <= '0;
            spr0    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        line    <= i_scanline;
                        h16     <= i_spr_h16;
                        cnt     <= '0;
                        spr0    <= 1'b0;
                        ovf     <= 1'b0;
                        n       <= '0;
                        m       <= '0;
                        clr_idx <= '0;
                        state   <= S_CLR;
                    end
                end
                S_CLR: begin
                    clr_idx <= clr_idx + 3'd1;
                    if (clr_idx == 3'd7)
                        state <= S_RDY;
                end
                S_RDY: state <= S_CMP;
                S_CMP: begin
                    if (!hit) begin
                        n <= n + 6'd1;
`ifdef PPU_SPR_OVF_BUG_EN
                        // m wraps without carrying into n
                        if (full)
                            m <= m + 2'd1;
`endif
                        state <= last ? S_DONE : S_RDY;
                    end else if (full) begin
                        ovf   <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        spr.y <= i_oam_q;
                        if (n == 6'd0)
                            spr0 <= 1'b1;
                        state <= S_RB1;
                    end
                end
                S_RB1: begin
                    spr.tile <= i_oam_q;
                    state    <= S_RB2;
                end
                S_RB2: begin
                    spr.attr <= i_oam_q;
                    state    <= S_RB3;
                end
                S_RB3: begin
                    spr.x <= i_oam_q;
                    state <= S_WR;
                end
                S_WR: begin
                    cnt   <= cnt + 4'd1;
                    n     <= n + 6'd1;
                    state <= last ? S_DONE : S_RDY;
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_oam_addr = '0;
        case (state)
            S_RDY: o_oam_addr = {n, m};
            S_CMP: o_oam_addr = {n, 2'd1};
            S_RB1: o_oam_addr = {n, 2'd2};
            S_RB2: o_oam_addr = {n, 2'd3};
            default: o_oam_addr = '0;
        endcase
    end

    always_comb begin
        o_oam2_we   = 1'b0;
        o_oam2_addr = '0;
        o_oam2_data = '0;
        case (state)
            S_CLR: begin
                o_oam2_we   = 1'b1;
                o_oam2_addr = clr_idx;
                o_oam2_data = OAM2_EMPTY;
            end
            S_WR: begin
                o_oam2_we   = 1'b1;
                o_oam2_addr = cnt[2:0];
                o_oam2_data = pack_spr(spr);
            end
            default: begin
                o_oam2_we   = 1'b0;
                o_oam2_addr = '0;
                o_oam2_data = '0;
            end
        endcase
    end

    assign o_busy     = (state != S_IDLE);
    assign o_done     = (state == S_DONE);
    assign o_spr_cnt  = cnt;
    assign o_spr0_in  = spr0;
    assign o_overflow = ovf;

endmodule

// File: tb/tb_ppu_spr_eval.sv
// Self-checking bench for ppu_spr_eval: directed cases plus random OAM
// images checked against a loop-level model of the evaluation rules.
module tb_ppu_spr_eval;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [8:0]  scanline;
    logic        h16;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_q;
    logic [2:0]  oam2_addr;
    logic [31:0] oam2_data;
    logic        oam2_we;
    logic        busy;
    logic        done;
    logic [3:0]  spr_cnt;
    logic        spr0_in;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  pmem [256];
    logic [31:0] got  [8];
    int          wr_cnt;
    bit          clr_bad;

    logic [31:0] exp_slot [8];
    int          exp_cnt;
    bit          exp_spr0;
    bit          exp_ovf;
    int          exp_cyc;

    ppu_spr_eval dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_start     (start),
        .i_scanline  (scanline),
        .i_spr_h16   (h16),
        .o_oam_addr  (oam_addr),
        .i_oam_q     (oam_q),
        .o_oam2_addr (oam2_addr),
        .o_oam2_data (oam2_data),
        .o_oam2_we   (oam2_we),
        .o_busy      (busy),
        .o_done      (done),
        .o_spr_cnt   (spr_cnt),
        .o_spr0_in   (spr0_in),
        .o_overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) oam_q <= pmem[oam_addr];

    always @(negedge clk) begin
        if (oam2_we === 1'b1) begin
            if (wr_cnt < 8 && (oam2_addr !== 3'(wr_cnt) ||
                               oam2_data !== 32'hFFFF_FFFF))
                clr_bad = 1'b1;
            got[oam2_addr] = oam2_data;
            wr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic bit in_range(int y, int s, bit tall);
        return (s >= y) && (s - y < (tall ? 16 : 8));
    endfunction

    task automatic model(input int s, input bit tall);
        int m;
        int y;
        bit stop;
        exp_cnt  = 0;
        exp_spr0 = 0;
        exp_ovf  = 0;
        exp_cyc  = 2 + 8;
        m        = 0;
        stop     = 0;
        for (int i = 0; i < 8; i++) exp_slot[i] = 32'hFFFF_FFFF;
        for (int n = 0; n < 64 && !stop; n++) begin
            exp_cyc += 2;
            if (exp_cnt < 8) begin
                y = int'(pmem[4*n]);
                if (in_range(y, s, tall)) begin
                    exp_slot[exp_cnt] = {pmem[4*n], pmem[4*n+1],
                                         pmem[4*n+2], pmem[4*n+3]};
                    exp_cnt++;
                    exp_cyc += 4;
                    if (n == 0) exp_spr0 = 1;
                end
            end else begin
`ifdef PPU_SPR_OVF_BUG_EN
                y = int'(pmem[4*n+m]);
`else
                y = int'(pmem[4*n]);
`endif
                if (in_range(y, s, tall)) begin
                    exp_ovf = 1;
                    stop    = 1;
                end else begin
`ifdef PPU_SPR_OVF_BUG_EN
                    m = (m + 1) % 4;
`endif
                end
            end
        end
    endtask

    task automatic clear_oam();
        for (int i = 0; i < 256; i++) pmem[i] = 8'hFF;
    endtask

    task automatic set_spr(input int i, input logic [7:0] y,
                           input logic [7:0] t, input logic [7:0] a,
                           input logic [7:0] x);
        pmem[4*i]   = y;
        pmem[4*i+1] = t;
        pmem[4*i+2] = a;
        pmem[4*i+3] = x;
    endtask

    task automatic run_eval(input string name, input int s, input bit tall);
        int cyc;
        model(s, tall);
        for (int i = 0; i < 8; i++) got[i] = 32'h0;
        wr_cnt  = 0;
        clr_bad = 0;
        @(negedge clk);
        scanline = 9'(s);
        h16      = tall;
        start    = 1'b1;
        cyc      = 1;
        @(negedge clk);
        start    = 1'b0;
        scanline = 9'h1AA;
        h16      = ~tall;
        cyc      = 2;
        check({name, " busy"}, 32'(busy), 32'd1);
        while (done !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " done_cycle"}, 32'(cyc), 32'(exp_cyc));
        check({name, " cnt"}, 32'(spr_cnt), 32'(exp_cnt));
        check({name, " spr0"}, 32'(spr0_in), 32'(exp_spr0));
        check({name, " ovf"}, 32'(overflow), 32'(exp_ovf));
        check({name, " writes"}, 32'(wr_cnt), 32'(8 + exp_cnt));
        check({name, " clr"}, 32'(clr_bad), 32'd0);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s slot%0d", name, i), got[i], exp_slot[i]);
        @(negedge clk);
        check({name, " idle"}, {30'd0, busy, done}, 32'd0);
    endtask

    task automatic check_zero(input string name);
        check({name, " addr"}, 32'(oam_addr), 32'd0);
        check({name, " oam2"}, {oam2_data}, 32'd0);
        check({name, " oam2_ctl"}, {28'd0, oam2_addr, oam2_we}, 32'd0);
        check({name, " stat"},
              {24'd0, spr_cnt, spr0_in, overflow, busy, done}, 32'd0);
    endtask

    initial begin
        int cyc;
        int w0;
        rstn     = 1'b0;
        start    = 1'b0;
        scanline = '0;
        h16      = 1'b0;
        wr_cnt   = 0;
        clr_bad  = 0;
        clear_oam();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rstn = 1'b1;

        clear_oam();
        run_eval("empty", 100, 1'b0);
        check("empty abs_cycle", 32'(exp_cyc), 32'd138);

        clear_oam();
        set_spr(0, 8'd95, 8'h12, 8'h41, 8'h80);
        run_eval("spr0", 100, 1'b0);
        check("spr0 word", got[0], 32'h5F12_4180);

        clear_oam();
        set_spr(5, 8'd90, 8'h33, 8'h02, 8'h10);
        run_eval("y90_h8", 100, 1'b0);
        check("y90_h8 n", 32'(spr_cnt), 32'd0);
        run_eval("y90_h16", 100, 1'b1);
        check("y90_h16 n", 32'(spr_cnt), 32'd1);

        clear_oam();
        set_spr(3, 8'd91, 8'h01, 8'h02, 8'h03);
        run_eval("borrow", 90, 1'b1);
        check("borrow n", 32'(spr_cnt), 32'd0);

        clear_oam();
        for (int i = 0; i < 10; i++)
            set_spr(i, 8'd50, 8'(i), 8'(8'h20 + i), 8'(8'h40 + i));
        run_eval("ovf10", 52, 1'b0);
        check("ovf10 flag", 32'(overflow), 32'd1);

        // abort a copy mid-flight, then evaluate again
        clear_oam();
        set_spr(0, 8'd60, 8'hA5, 8'h5A, 8'h77);
        @(negedge clk);
        scanline = 9'd61;
        h16      = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (!(oam_addr === 8'h03 && busy === 1'b1) && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("rst wait_rb2", 32'(cyc < 60), 32'd1);
        rstn = 1'b0;
        #1;
        check_zero("rst_mid");
        w0 = wr_cnt;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        check("rst no_we", 32'(wr_cnt), 32'(w0));
        check("rst idle", {30'd0, busy, done}, 32'd0);
        run_eval("after_rst", 61, 1'b0);

        clear_oam();
        for (int i = 0; i < 8; i++)
            set_spr(i, 8'd50, 8'(i), 8'h00, 8'(i * 3));
        pmem[4*9+1] = 8'd50;
        run_eval("bugscan", 52, 1'b0);
`ifdef PPU_SPR_OVF_BUG_EN
        check("bugscan flag", 32'(overflow), 32'd1);
`else
        check("bugscan flag", 32'(overflow), 32'd0);
`endif

        for (int r = 0; r < 12; r++) begin
            int ln;
            int yv;
            bit tall;
            ln   = int'($urandom_range(0, 239));
            tall = bit'($urandom_range(0, 1));
            for (int i = 0; i < 256; i++) pmem[i] = 8'($urandom_range(0, 255));
            for (int i = 0; i < 64; i++) begin
                if ($urandom_range(0, 2) == 0)
                    yv = ln - int'($urandom_range(0, 17));
                else
                    yv = int'($urandom_range(0, 255));
                if (yv < 0) yv = 255;
                pmem[4*i] = 8'(yv);
            end
            run_eval($sformatf("rnd%0d", r), ln, tall);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
